seq_restoring_divider: RTL and testbench

//   Sequential unsigned restoring divider; inverse datapath of the 4x4 Dadda multiplier.

---
 rtl/seq_restoring_divider.sv | 160 ++++++++++++++++
 tb/tb_seq_restoring_divider.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// -----------------------------------------------------------------------------
// seq_restoring_divider
//   Sequential unsigned restoring divider, one quotient bit per clock, MSB
//   first. Companion to the 4x4 Dadda multiplier so that
//   (quotient * divisor) + remainder == dividend for every nonzero divisor.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operands valid          in_ready   accepting (IDLE only)
//   dividend   DIVIDEND_W-bit operand  divisor    DIVISOR_W-bit operand
//   out_valid  result valid            out_ready  downstream accepts result
//   quotient   DIVIDEND_W-bit result   remainder  DIVISOR_W-bit result
//   dbz        result came from a zero divisor
//
// Configuration macro
//   DIV_ZERO_FAST_EN  when defined, a zero divisor skips RUN and the result
//                     is available right after the accept edge. When not
//                     defined, every operation takes DIVIDEND_W cycles.
//
// States
//   state  | meaning
//   IDLE   | waiting for an operation, in_ready=1
//   RUN    | one restoring iteration per cycle
//   DONE   | result held until out_ready
// -----------------------------------------------------------------------------
module seq_restoring_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  dbz
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0]   dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]    dvs_q, dvs_d;
  logic [DIVISOR_W-1:0]    p_q, p_d;
  logic [DIVIDEND_W-1:0]   quo_q, quo_d;
  logic [DIVIDEND_W-1:0]   quotient_q, quotient_d;
  logic [DIVISOR_W-1:0]    remainder_q, remainder_d;
  logic                    dbz_q, dbz_d;

  // The partial remainder is always below the divisor between iterations
  // (or is simply the low dividend bits when the divisor is zero), so only
  // its low DIVISOR_W bits need to be stored; the shifted value P' carries
  // the extra bit for the compare.
  logic [DIVISOR_W:0]      p_shift;
  logic [DIVISOR_W-1:0]    p_sub;
  logic [DIVISOR_W-1:0]    p_next;
  logic                    borrow;
  logic                    q_bit;

  always_comb begin
    p_shift = {p_q, dvd_q[DIVIDEND_W-1]};
    borrow  = (p_shift < {1'b0, dvs_q});
    p_sub   = p_shift[DIVISOR_W-1:0] - dvs_q;
    p_next  = borrow ? p_shift[DIVISOR_W-1:0] : p_sub;
    q_bit   = ~borrow;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    p_d         = p_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          p_d     = '0;
          quo_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
`ifdef DIV_ZERO_FAST_EN
          if (divisor == '0) begin
            state_d     = S_DONE;
            quotient_d  = '1;
            remainder_d = dividend[DIVISOR_W-1:0];
            dbz_d       = 1'b1;
          end
`endif
        end
      end
      S_RUN: begin
        p_d   = p_next;
        quo_d = {quo_q[DIVIDEND_W-2:0], q_bit};
        dvd_d = {dvd_q[DIVIDEND_W-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d     = S_DONE;
          cnt_d       = '0;
          quotient_d  = {quo_q[DIVIDEND_W-2:0], q_bit};
          remainder_d = p_next;
          dbz_d       = (dvs_q == '0);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      p_q         <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      p_q         <= p_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
module tb_seq_restoring_divider;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       dbz;

  int vectors     = 0;
  int miscompares = 0;

`ifdef DIV_ZERO_FAST_EN
  localparam int DZ_LAT = 0;
`else
  localparam int DZ_LAT = 8;
`endif

  seq_restoring_divider #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full operation: accept, wait for the result while wiggling the
  // inputs (which must be ignored), check, optionally stall, then drain.
  task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                        input logic [7:0] eq, input logic [3:0] er,
                        input logic edbz, input int hold);
    int   lat;
    int   elat;
    logic bad_ready;
    elat = (b == 4'd0) ? DZ_LAT : 8;
    check("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    dividend  = ~a;
    divisor   = ~b;
    lat       = 0;
    bad_ready = 1'b0;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (in_ready !== 1'b0) bad_ready = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check("latency", lat, elat);
    check("in_ready_low_in_run", bad_ready, 0);
    check("in_ready_low_in_done", in_ready, 0);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("dbz", dbz, edbz);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("held_out_valid", out_valid, 1);
      check("held_quotient", quotient, eq);
      check("held_remainder", remainder, er);
      check("held_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_after_drain", out_valid, 0);
    check("in_ready_after_drain", in_ready, 1);
    check("quotient_kept_in_idle", quotient, eq);
  endtask

  initial begin
    logic [7:0] ra;
    logic [3:0] rb;
    logic [7:0] rq;
    logic [3:0] rr;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 8'd0;
    divisor   = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_quotient", quotient, 0);
    check("reset_remainder", remainder, 0);
    check("reset_dbz", dbz, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8'd200, 4'd7,  8'd28,  4'd4,  1'b0, 0);
    run_op(8'd255, 4'd1,  8'd255, 4'd0,  1'b0, 0);
    run_op(8'hA5,  4'd0,  8'hFF,  4'h5,  1'b1, 0);
    run_op(8'd13,  4'd15, 8'd0,   4'd13, 1'b0, 0);
    run_op(8'd0,   4'd9,  8'd0,   4'd0,  1'b0, 0);
    run_op(8'd255, 4'd15, 8'd17,  4'd0,  1'b0, 0);
    run_op(8'd250, 4'd15, 8'd16,  4'd10, 1'b0, 0);
    run_op(8'd15,  4'd4,  8'd3,   4'd3,  1'b0, 0);
    run_op(8'd0,   4'd0,  8'hFF,  4'd0,  1'b1, 0);
    run_op(8'd100, 4'd3,  8'd33,  4'd1,  1'b0, 5);

    // Abort mid-RUN: 77/5 accepted, reset asserted at iteration 4.
    in_valid = 1'b1;
    dividend = 8'd77;
    divisor  = 4'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_run_in_ready", in_ready, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_out_valid", out_valid, 0);
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_in_ready", in_ready, 1);
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_result", out_valid, 0);
    run_op(8'd77, 4'd5, 8'd15, 4'd2, 1'b0, 0);

    for (int n = 0; n < 30; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 4'($urandom_range(0, 15));
      if (rb == 4'd0) begin
        rq = 8'hFF;
        rr = ra[3:0];
      end else begin
        rq = ra / {4'd0, rb};
        rr = 4'(ra % {4'd0, rb});
      end
      run_op(ra, rb, rq, rr, (rb == 4'd0), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
